// File: rtl/fetch_aligner.sv
// Fetch-to-decode aligner: queues fetch blocks as halfwords and presents one
// 16- or 32-bit instruction per handshake with its PC; redirects drop stale blocks.
module fetch_aligner #(
  parameter int unsigned FETCH_BYTES = 4,
  parameter int unsigned QUEUE_HW    = 8,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          C_EN        = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_valid_i,
  output logic                     fetch_ready_o,
  input  logic [31:0]              fetch_addr_i,
  input  logic [8*FETCH_BYTES-1:0] fetch_data_i,
  input  logic                     flush_i,
  input  logic [31:0]              flush_pc_i,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [31:0]              instr_o,
  output logic [31:0]              instr_pc_o,
  output logic                     instr_compressed_o,
  output logic                     instr_illegal_o
);

  localparam int unsigned N  = FETCH_BYTES / 2;
  localparam int unsigned PW = $clog2(QUEUE_HW);
  localparam int unsigned CW = $clog2(QUEUE_HW + 1);
  localparam int unsigned SW = $clog2(N);
  localparam logic [31:0] ALIGN_MASK = ~(32'(FETCH_BYTES) - 32'd1);

  logic [15:0]   mem [QUEUE_HW];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   pc_q, exp_q;
  logic [SW-1:0] skip_q;

  logic [15:0]   hw0, hw1;
  logic          is_c, push, pop;
  logic [CW-1:0] push_n, pop_n;

  assign hw0 = mem[rd_q];
  assign hw1 = mem[rd_q + PW'(1)];
  assign is_c = C_EN && (hw0[1:0] != 2'b11);

  assign fetch_ready_o = !flush_i && ((CW'(QUEUE_HW) - count_q) >= CW'(N));
  assign instr_valid_o = !flush_i &&
                         (((count_q != '0) && is_c) || (count_q >= CW'(2)));

  assign instr_o            = is_c ? {16'h0000, hw0} : {hw1, hw0};
  assign instr_pc_o         = pc_q;
  assign instr_compressed_o = is_c;
  assign instr_illegal_o    = !C_EN && (hw0[1:0] != 2'b11);

  // Blocks not at the expected address are consumed but never pushed.
  assign push   = fetch_valid_i && fetch_ready_o && (fetch_addr_i == exp_q);
  assign pop    = instr_valid_o && instr_ready_i;
  assign push_n = push ? (CW'(N) - CW'(skip_q)) : '0;
  assign pop_n  = pop ? (is_c ? CW'(1) : CW'(2)) : '0;

  // Storage carries no reset; validity is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < int'(N); i++) begin
        if (i >= int'(skip_q)) begin
          mem[wr_q + PW'(i - int'(skip_q))] <= fetch_data_i[16*i +: 16];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      pc_q    <= RESET_PC;
      exp_q   <= RESET_PC & ALIGN_MASK;
      skip_q  <= RESET_PC[SW:1];
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      pc_q    <= flush_pc_i;
      exp_q   <= flush_pc_i & ALIGN_MASK;
      skip_q  <= flush_pc_i[SW:1];
    end else begin
      if (push) begin
        wr_q   <= wr_q + PW'(push_n);
        skip_q <= '0;
        exp_q  <= exp_q + 32'(FETCH_BYTES);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(pop_n);
        pc_q <= pc_q + (is_c ? 32'd2 : 32'd4);
      end
      count_q <= count_q + push_n - pop_n;
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner: one C-enabled instance and one C-disabled
// instance share stimulus; expected values are hand-computed constants.
module tb_fetch_aligner;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        flush;
  logic [31:0] flush_pc;
  logic        instr_ready;

  logic        fetch_ready, instr_valid, instr_comp, instr_ill;
  logic [31:0] instr, instr_pc;
  logic        nc_fetch_ready, nc_instr_valid, nc_instr_comp, nc_instr_ill;
  logic [31:0] nc_instr, nc_instr_pc;

  int total  = 0;
  int passed = 0;

  fetch_aligner #(.FETCH_BYTES(4), .QUEUE_HW(8), .RESET_PC(32'h0), .C_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready),
    .fetch_addr_i(fetch_addr), .fetch_data_i(fetch_data),
    .flush_i(flush), .flush_pc_i(flush_pc),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .instr_pc_o(instr_pc),
    .instr_compressed_o(instr_comp), .instr_illegal_o(instr_ill)
  );

  fetch_aligner #(.FETCH_BYTES(4), .QUEUE_HW(8), .RESET_PC(32'h0), .C_EN(1'b0)) u_nc (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid_i(fetch_valid), .fetch_ready_o(nc_fetch_ready),
    .fetch_addr_i(fetch_addr), .fetch_data_i(fetch_data),
    .flush_i(flush), .flush_pc_i(flush_pc),
    .instr_valid_o(nc_instr_valid), .instr_ready_i(instr_ready),
    .instr_o(nc_instr), .instr_pc_o(nc_instr_pc),
    .instr_compressed_o(nc_instr_comp), .instr_illegal_o(nc_instr_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_block(input logic [31:0] addr, input logic [31:0] data);
    fetch_valid = 1'b1;
    fetch_addr  = addr;
    fetch_data  = data;
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
    #1;
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush    = 1'b1;
    flush_pc = pc;
    #1;
    chk("flush_valid_low", 32'(instr_valid), 32'd0);
    chk("flush_ready_low", 32'(fetch_ready), 32'd0);
    cyc();
    flush = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_addr = '0; fetch_data = '0;
    flush = 1'b0; flush_pc = '0; instr_ready = 1'b0;
    cyc(); cyc();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    rst_n = 1'b1;
    cyc();

    // T1: single 32-bit instruction
    drive_block(32'h0, 32'h0000_0013);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_instr", instr, 32'h0000_0013);
    chk("t1_pc", instr_pc, 32'h0);
    chk("t1_comp", 32'(instr_comp), 32'd0);
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    #1;
    chk("t1_after_valid", 32'(instr_valid), 32'd0);
    chk("t1_after_pc", instr_pc, 32'h4);

    // T2: two compressed instructions in one block
    do_flush(32'h0);
    drive_block(32'h0, 32'h4505_0001);
    chk("t2_instr0", instr, 32'h0000_0001);
    chk("t2_pc0", instr_pc, 32'h0);
    chk("t2_comp0", 32'(instr_comp), 32'd1);
    instr_ready = 1'b1;
    cyc();
    chk("t2_valid1", 32'(instr_valid), 32'd1);
    chk("t2_instr1", instr, 32'h0000_4505);
    chk("t2_pc1", instr_pc, 32'h2);
    chk("t2_comp1", 32'(instr_comp), 32'd1);
    cyc();
    chk("t2_empty", 32'(instr_valid), 32'd0);
    chk("t2_pc_end", instr_pc, 32'h4);
    instr_ready = 1'b0;

    // T3: 32-bit instruction spanning two blocks
    do_flush(32'h0);
    drive_block(32'h0, 32'h0513_0001);
    chk("t3_instr0", instr, 32'h0000_0001);
    chk("t3_pc0", instr_pc, 32'h0);
    instr_ready = 1'b1;
    cyc();
    chk("t3_half_wait", 32'(instr_valid), 32'd0);
    chk("t3_half_pc", instr_pc, 32'h2);
    cyc();
    chk("t3_still_wait", 32'(instr_valid), 32'd0);
    drive_block(32'h4, 32'h0001_0000);
    chk("t3_span_valid", 32'(instr_valid), 32'd1);
    chk("t3_span_instr", instr, 32'h0000_0513);
    chk("t3_span_pc", instr_pc, 32'h2);
    chk("t3_span_comp", 32'(instr_comp), 32'd0);
    cyc();
    chk("t3_last_instr", instr, 32'h0000_0001);
    chk("t3_last_pc", instr_pc, 32'h6);
    chk("t3_last_comp", 32'(instr_comp), 32'd1);
    cyc();
    chk("t3_drained", 32'(instr_valid), 32'd0);
    instr_ready = 1'b0;

    // T4: redirect to a mid-block target, stale block dropped
    do_flush(32'h102);
    chk("t4_pc_after_flush", instr_pc, 32'h102);
    drive_block(32'h8, 32'hDEAD_BEEF);
    chk("t4_stale_dropped", 32'(instr_valid), 32'd0);
    drive_block(32'h100, 32'h0001_ABCD);
    chk("t4_valid", 32'(instr_valid), 32'd1);
    chk("t4_instr", instr, 32'h0000_0001);
    chk("t4_pc", instr_pc, 32'h102);
    chk("t4_comp", 32'(instr_comp), 32'd1);
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    #1;
    chk("t4_drained", 32'(instr_valid), 32'd0);
    chk("t4_pc_next", instr_pc, 32'h104);

    // T5: backpressure fills the queue
    drive_block(32'h104, 32'h00A0_0093);
    drive_block(32'h108, 32'h0010_0113);
    drive_block(32'h10C, 32'h0020_0193);
    chk("t5_ready_3blk", 32'(fetch_ready), 32'd1);
    drive_block(32'h110, 32'h0030_0213);
    chk("t5_full_ready", 32'(fetch_ready), 32'd0);
    chk("t5_head_instr", instr, 32'h00A0_0093);
    chk("t5_head_pc", instr_pc, 32'h104);
    fetch_valid = 1'b1; fetch_addr = 32'h114; fetch_data = 32'h0040_0293;
    cyc();
    fetch_valid = 1'b0;
    #1;
    chk("t5_stable_instr", instr, 32'h00A0_0093);
    chk("t5_stable_pc", instr_pc, 32'h104);
    chk("t5_stable_ready", 32'(fetch_ready), 32'd0);
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    #1;
    chk("t5_reraised", 32'(fetch_ready), 32'd1);
    chk("t5_next_instr", instr, 32'h0010_0113);
    chk("t5_next_pc", instr_pc, 32'h108);

    // T6: asynchronous reset mid-stream, then C-disabled behaviour
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(instr_valid), 32'd0);
    chk("t6_rst_pc", instr_pc, 32'h0);
    chk("t6_nc_rst_pc", nc_instr_pc, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    drive_block(32'h0, 32'h0000_0001);
    chk("t6_nc_valid", 32'(nc_instr_valid), 32'd1);
    chk("t6_nc_illegal", 32'(nc_instr_ill), 32'd1);
    chk("t6_nc_comp", 32'(nc_instr_comp), 32'd0);
    chk("t6_nc_instr", nc_instr, 32'h0000_0001);
    chk("t6_c_comp", 32'(instr_comp), 32'd1);
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    #1;
    chk("t6_nc_pc_adv", nc_instr_pc, 32'h4);
    chk("t6_nc_drained", 32'(nc_instr_valid), 32'd0);
    chk("t6_c_pc_adv", instr_pc, 32'h2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
